req_initiator: RTL and testbench
================================

REQ_INITIATOR -- requirements
Module: req_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning: number of edges the block waits for gnt after raising req (legal range 2..255).
REQ-002 Parameter HOLD_W, default 4, meaning: width of hold_cycles.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rstn  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  single-cycle request to begin one req/gnt transaction.
REQ-006 Port hold_cycles  input  HOLD_W  extra cycles req stays high after grant; sampled with start.
REQ-007 Port gnt  input  1  grant from responder (responder registers gnt from req).
REQ-008 Port req  output  1  registered request to responder.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port done  output  1  one-cycle pulse on clean handshake completion.
REQ-011 Port timeout_err  output  1  one-cycle pulse when grant or release times out.
REQ-012 Port proto_err  output  1  one-cycle pulse when gnt drops during HOLD.
REQ-013 Port grant_count  output  16  number of completed grants (see Configuration).
REQ-014 Port last_latency  output  8  edges from req rise to gnt sampled high, last grant.

Function
REQ-015 FSM states IDLE, REQ, HOLD, REL; req=1 exactly in REQ and HOLD; all outputs registered.
REQ-016 IDLE: start=1 sampled at edge T -> REQ, req=1 after T, latch hold_cycles, clear wait counter.
REQ-017 start while busy=1 is ignored; no queuing, no error.
REQ-018 REQ: wait counter increments every edge; gnt=1 sampled -> HOLD with hold counter = latched hold_cycles, last_latency = edges since T.
REQ-019 REQ: wait counter reaches TIMEOUT_CYCLES with gnt=0 -> IDLE, req=0, timeout_err=1 for one cycle.
REQ-020 gnt=1 on the same edge as timeout expiry: grant wins, no timeout_err.
REQ-021 HOLD: counter==0 -> REL (req=0); else decrement; req therefore deasserts after edge G+1+hold_cycles, G = gnt-sample edge.
REQ-022 HOLD: gnt=0 sampled -> REL immediately, proto_err=1 for one cycle, grant not counted.
REQ-023 REL: wait counter restarts; gnt=0 sampled -> IDLE with done=1 one cycle (unless entered via proto_err); no gnt=0 within TIMEOUT_CYCLES -> IDLE, timeout_err=1.
REQ-024 done, timeout_err, proto_err mutually exclusive in any cycle.
REQ-025 grant_count saturates at 16'hFFFF; increments on each done; last_latency saturates at 8'hFF.

Reset
REQ-026 rstn=0 asynchronously forces IDLE: req=0, busy=0, done=0, timeout_err=0, proto_err=0, grant_count=0, last_latency=0, counters=0.
REQ-027 Reset mid-transaction aborts it with no done/error pulse; first start after rstn release behaves per REQ-016.

Configuration
REQ-028 Macro REQ_INITIATOR_STATS_EN defined: grant_count and last_latency operate per REQ-018/REQ-025.
REQ-029 Macro undefined: grant_count and last_latency ports remain present but are constant 0; no statistics registers synthesized; all other behaviour identical.

Verification
REQ-030 Responder = one-cycle registered echo (gnt<=req); start at edge T, hold_cycles=0 -> req high after T, gnt sampled T+2, req low after T+3, done=1 after T+5, last_latency=2.
REQ-031 Same responder, hold_cycles=3 -> req low after T+6, done after T+8, grant_count=1.
REQ-032 gnt tied 0, TIMEOUT_CYCLES=16 -> timeout_err pulse after edge T+16, req low, busy low, grant_count unchanged.
REQ-033 Responder drops gnt one cycle into HOLD (hold_cycles=5) -> proto_err pulse, req low next, no done, grant_count unchanged.
REQ-034 start pulsed again while busy, then rstn=0 during HOLD -> second start ignored; reset clears req/busy immediately with no done/error pulse.
REQ-035 Build without REQ_INITIATOR_STATS_EN, run REQ-030 -> identical req/done timing, grant_count=0, last_latency=0.

Source files
------------

// File: rtl/req_initiator.sv
// Request/grant initiator: raises req on start, holds it after grant, then waits for release.
// Optional statistics (grant_count, last_latency) are built only when REQ_INITIATOR_STATS_EN is defined.
module req_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int HOLD_W         = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              gnt,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [15:0]       grant_count,
  output logic [7:0]        last_latency
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;
  // Expiry is detected one count early so the pulse lands on edge T+TIMEOUT_CYCLES.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_r, state_s;
  logic [7:0]        wait_r, wait_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic              proto_seen_r, proto_seen_s;
  logic              req_r, busy_r, done_r, terr_r, perr_r;
  logic              done_s, terr_s, perr_s;

  // Next-state and pulse decode for the handshake FSM.
  always_comb begin
    state_s      = state_r;
    wait_s       = wait_r;
    hold_s       = hold_r;
    proto_seen_s = proto_seen_r;
    done_s       = 1'b0;
    terr_s       = 1'b0;
    perr_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s      = S_REQ;
          wait_s       = 8'd0;
          hold_s       = hold_cycles;
          proto_seen_s = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (gnt) begin
          state_s = S_HOLD;
        end else if (wait_r == WAIT_LAST) begin
          state_s = S_IDLE;
          terr_s  = 1'b1;
        end else begin
          wait_s = wait_r + 8'd1;
        end
      end
      S_HOLD: begin
        if (!gnt) begin
          state_s      = S_REL;
          wait_s       = 8'd0;
          perr_s       = 1'b1;
          proto_seen_s = 1'b1;
        end else if (hold_r == '0) begin
          state_s = S_REL;
          wait_s  = 8'd0;
        end else begin
          hold_s = hold_r - 1'b1;
        end
      end
      S_REL: begin
        if (!gnt) begin
          state_s = S_IDLE;
          done_s  = !proto_seen_r;
        end else if (wait_r == WAIT_LAST) begin
          state_s = S_IDLE;
          terr_s  = 1'b1;
        end else begin
          wait_s = wait_r + 8'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      wait_r       <= 8'd0;
      hold_r       <= '0;
      proto_seen_r <= 1'b0;
      req_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      terr_r       <= 1'b0;
      perr_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_r       <= wait_s;
      hold_r       <= hold_s;
      proto_seen_r <= proto_seen_s;
      req_r        <= (state_s == S_REQ) || (state_s == S_HOLD);
      busy_r       <= (state_s != S_IDLE);
      done_r       <= done_s;
      terr_r       <= terr_s;
      perr_r       <= perr_s;
    end
  end

  assign req         = req_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout_err = terr_r;
  assign proto_err   = perr_r;

`ifdef REQ_INITIATOR_STATS_EN
  logic [15:0] grant_count_r;
  logic [7:0]  last_latency_r;
  logic        grant_s;
  logic [7:0]  lat_s;

  // Latency counts edges since start, so it is the wait count plus the sampling edge.
  always_comb begin
    grant_s = (state_r == S_REQ) && gnt;
    if (wait_r == 8'hFF) begin
      lat_s = 8'hFF;
    end else begin
      lat_s = wait_r + 8'd1;
    end
  end

  // Saturating grant counter and last grant latency capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_count_r  <= 16'h0000;
      last_latency_r <= 8'h00;
    end else begin
      if (done_s && (grant_count_r != 16'hFFFF)) begin
        grant_count_r <= grant_count_r + 16'd1;
      end
      if (grant_s) begin
        last_latency_r <= lat_s;
      end
    end
  end

  assign grant_count  = grant_count_r;
  assign last_latency = last_latency_r;
`else
  assign grant_count  = 16'h0000;
  assign last_latency = 8'h00;
`endif

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator with a registered-echo responder and an event scoreboard.
module tb_req_initiator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  hold_cycles = 4'd0;
  logic        gnt;
  logic        req, busy, done, timeout_err, proto_err;
  logic [15:0] grant_count;
  logic [7:0]  last_latency;

`ifdef REQ_INITIATOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;
  bit  kill = 1'b0;

  typedef struct {
    int kind;
    int rel;
    int fall;
    int lat;
    int cnt;
  } exp_t;
  exp_t sb[$];

  req_initiator #(.TIMEOUT_CYCLES(16), .HOLD_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .hold_cycles(hold_cycles), .gnt(gnt),
    .req(req), .busy(busy), .done(done), .timeout_err(timeout_err), .proto_err(proto_err),
    .grant_count(grant_count), .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Responder: one-cycle registered echo, forced low while kill is set.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) gnt <= 1'b0;
    else       gnt <= req & ~kill;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input int hold, input bit kill_init,
                         input int kill_off_at, input int kill_on_at, input int extra_at,
                         input int kind, input int rel, input int fall, input int lat, input int cnt);
    exp_t e, o;
    int   t0, fall_obs, r;
    bit   got;
    @(negedge clk);
    kill = kill_init;
    start = 1'b1;
    hold_cycles = 4'(hold);
    t0 = edge_cnt + 1;
    e.kind = kind; e.rel = rel; e.fall = fall;
    e.lat = STATS ? lat : 0;
    e.cnt = STATS ? cnt : 0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    hold_cycles = 4'd0;
    chk({tag, "_req_up"}, int'(req), 1);
    chk({tag, "_busy_up"}, int'(busy), 1);
    fall_obs = -1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      r = edge_cnt - t0;
      if (r == kill_off_at) kill = 1'b0;
      if (r == kill_on_at) kill = 1'b1;
      start = (r == extra_at);
      if (fall_obs < 0 && !req) fall_obs = r;
      chk({tag, "_excl"}, int'($countones({done, timeout_err, proto_err}) <= 1), 1);
      if (done | timeout_err | proto_err) got = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    if (!got) chk({tag, "_pulse_seen"}, 0, 1);
    o.kind = done ? 0 : (timeout_err ? 1 : 2);
    o.rel  = edge_cnt - t0;
    o.fall = fall_obs;
    o.lat  = int'(last_latency);
    o.cnt  = int'(grant_count);
    if (kind != 2) chk({tag, "_busy_end"}, int'(busy), 0);
    e = sb.pop_front();
    chk({tag, "_kind"}, o.kind, e.kind);
    chk({tag, "_pulse_edge"}, o.rel, e.rel);
    chk({tag, "_req_fall_edge"}, o.fall, e.fall);
    chk({tag, "_last_latency"}, o.lat, e.lat);
    chk({tag, "_grant_count"}, o.cnt, e.cnt);
    kill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_no_extra_pulse"}, int'(done | timeout_err | proto_err), 0);
    end
    chk({tag, "_idle_after"}, int'(busy | req), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'(done | timeout_err | proto_err), 0);
    chk("rst_grant_count", int'(grant_count), 0);
    chk("rst_last_latency", int'(last_latency), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // tag, hold, kill_init, kill_off_at, kill_on_at, extra_at, kind, rel, fall, lat, cnt
    run_txn("echo_h0",    0, 1'b0, -1, -1, -1, 0,  5,  3,  2, 1);
    run_txn("echo_h3",    3, 1'b0, -1, -1,  1, 0,  8,  6,  2, 2);
    run_txn("tied0",      0, 1'b1, -1, -1, -1, 1, 16, 16,  2, 2);
    run_txn("gnt_at_exp", 0, 1'b1, 14, -1, -1, 0, 19, 17, 16, 3);
    run_txn("proto",      5, 1'b0, -1,  1, -1, 2,  3,  3,  2, 3);

    // Second start while busy, then reset during HOLD.
    @(negedge clk);
    start = 1'b1;
    hold_cycles = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_in_hold_req", int'(req), 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_req", int'(req), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_pulses", int'(done | timeout_err | proto_err), 0);
    chk("rst_mid_grant_count", int'(grant_count), 0);
    chk("rst_mid_last_latency", int'(last_latency), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(done | timeout_err | proto_err | req | busy), 0);
    end
    run_txn("after_rst", 0, 1'b0, -1, -1, -1, 0, 5, 3, 2, 1);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule
